// File: rtl/csr_row_sequencer.sv
// CSR row sequencer: walks row pointers, issues nonzero indices and steers the row accumulator.
// Define SMVM_SEQ_PERF_EN to build the perf_stall cycle counter; otherwise perf_stall is tied to 0.
module csr_row_sequencer #(
  parameter int ROW_W = 16,
  parameter int NZ_W  = 16
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             start,
  input  logic [ROW_W-1:0] num_rows,
  output logic             rp_rd,
  output logic [ROW_W-1:0] rp_addr,
  input  logic [NZ_W-1:0]  rp_data,
  output logic             nz_valid,
  output logic [NZ_W-1:0]  nz_idx,
  input  logic             nz_ready,
  input  logic             prod_valid,
  output logic             acc_en,
  output logic             acc_clear,
  output logic             row_valid,
  output logic [ROW_W-1:0] row_idx,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      perf_stall
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_START, S_LD_END, S_ISSUE, S_DRAIN, S_EMIT, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [NZ_W-1:0]  cur_q, cur_d, end_q, end_d, len_q, len_d;
  logic [NZ_W-1:0]  issued_q, issued_d, acc_cnt_q, acc_cnt_d;
  logic [ROW_W-1:0] r_q, r_d, num_rows_q, num_rows_d;
  logic [ROW_W-1:0] rp_addr_q, rp_addr_d;
  logic             rp_rd_q, rp_rd_d, nz_valid_q, nz_valid_d;
  logic             acc_clear_q, acc_clear_d, row_valid_q, row_valid_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             start_go, prod_ok;

  assign start_go = (state_q == S_IDLE) && start;
  // A product is only legal while a row is in flight and at least one issued index is still unmatched.
  assign prod_ok  = prod_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                    (acc_cnt_q != issued_q);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    len_d      = len_q;
    issued_d   = issued_q;
    acc_cnt_d  = acc_cnt_q;
    r_d        = r_q;
    num_rows_d = num_rows_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_rows_d = num_rows;
          r_d        = '0;
          state_d    = (num_rows == '0) ? S_FIN : S_LD_START;
        end
      end
      S_LD_START: begin
        cur_d   = rp_data;
        state_d = S_LD_END;
      end
      S_LD_END: begin
        end_d     = rp_data;
        len_d     = rp_data - cur_q;
        issued_d  = '0;
        acc_cnt_d = '0;
        state_d   = (rp_data == cur_q) ? S_EMIT : S_ISSUE;
      end
      S_ISSUE: begin
        if (nz_ready) begin
          cur_d    = cur_q + NZ_W'(1);
          issued_d = issued_q + NZ_W'(1);
          if ((cur_q + NZ_W'(1)) == end_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (acc_cnt_q == len_q) state_d = S_EMIT;
      end
      S_EMIT: begin
        r_d     = r_q + ROW_W'(1);
        state_d = ((r_q + ROW_W'(1)) == num_rows_q) ? S_FIN : S_LD_END;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (prod_ok) acc_cnt_d = acc_cnt_q + NZ_W'(1);
    err_d = err_q | (prod_valid & ~prod_ok);

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d      = (state_d != S_IDLE);
    nz_valid_d  = (state_d == S_ISSUE);
    acc_clear_d = (state_d == S_LD_END);
    row_valid_d = (state_d == S_EMIT);
    done_d      = (state_d == S_FIN);
    rp_rd_d     = (state_d == S_LD_START) ||
                  ((state_d == S_EMIT) && ((r_d + ROW_W'(1)) != num_rows_d));
    rp_addr_d   = '0;
    if (state_d == S_LD_START) rp_addr_d = r_d + ROW_W'(1);
    else if (rp_rd_d)          rp_addr_d = r_d + ROW_W'(2);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      acc_cnt_q   <= '0;
      r_q         <= '0;
      num_rows_q  <= '0;
      rp_addr_q   <= '0;
      rp_rd_q     <= 1'b0;
      nz_valid_q  <= 1'b0;
      acc_clear_q <= 1'b0;
      row_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      acc_cnt_q   <= acc_cnt_d;
      r_q         <= r_d;
      num_rows_q  <= num_rows_d;
      rp_addr_q   <= rp_addr_d;
      rp_rd_q     <= rp_rd_d;
      nz_valid_q  <= nz_valid_d;
      acc_clear_q <= acc_clear_d;
      row_valid_q <= row_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // The first row-pointer read must go out in the same cycle start is seen.
  assign rp_rd     = rp_rd_q | (start_go && (num_rows != '0));
  assign rp_addr   = rp_addr_q;
  assign nz_valid  = nz_valid_q;
  assign nz_idx    = nz_valid_q ? cur_q : '0;
  assign acc_en    = prod_ok;
  assign acc_clear = acc_clear_q;
  assign row_valid = row_valid_q;
  assign row_idx   = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef SMVM_SEQ_PERF_EN
  logic [31:0] perf_q;
  logic        stall;

  assign stall = ((state_q == S_ISSUE) && !nz_ready) || (state_q == S_DRAIN);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                            perf_q <= '0;
    else if (start_go)                     perf_q <= '0;
    else if (stall && (perf_q != '1))      perf_q <= perf_q + 32'd1;
  end

  assign perf_stall = perf_q;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_csr_row_sequencer.sv
// Bench for csr_row_sequencer: row-pointer memory, product pipeline and accumulator around the DUT,
// checked against row sums and index order computed directly from the CSR arrays.
module tb_csr_row_sequencer;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_rows = '0;
  logic        rp_rd;
  logic [15:0] rp_addr;
  logic [15:0] rp_data = '0;
  logic        nz_valid;
  logic [15:0] nz_idx;
  logic        nz_ready = 1'b0;
  logic        prod_valid = 1'b0;
  logic        acc_en, acc_clear, row_valid;
  logic [15:0] row_idx;
  logic        busy, done, err;
  logic [31:0] perf_stall;

  csr_row_sequencer #(.ROW_W(16), .NZ_W(16)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .num_rows(num_rows),
    .rp_rd(rp_rd), .rp_addr(rp_addr), .rp_data(rp_data),
    .nz_valid(nz_valid), .nz_idx(nz_idx), .nz_ready(nz_ready),
    .prod_valid(prod_valid), .acc_en(acc_en), .acc_clear(acc_clear),
    .row_valid(row_valid), .row_idx(row_idx), .busy(busy), .done(done),
    .err(err), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  logic [15:0] rp_mem [0:63];
  logic [31:0] val_mem [0:1023];
  int          n_run = 0, n_fail = 0;
  int          cyc = 0, rdy_mode = 0, dly = 2;
  bit          tog = 1'b1, inj_emit = 1'b0, injected = 1'b0;
  int          pq_due[$], pq_idx[$];
  logic [15:0] rd_next = '0;
  logic [31:0] acc = '0, pval = '0;
  int          iss_q[$], rv_idx[$];
  logic [31:0] rv_sum[$];
  int          done_cnt, rprd_cnt, stall_cnt, viol_cnt, first_addr, inj_seen, inj_accen;
  bit          prev_nzv = 1'b0, prev_hs = 1'b0;

  // Environment: drives inputs on the falling edge, then samples what the next rising edge will see.
  always @(negedge clk) begin
    cyc++;
    if (!rst_l) begin
      pq_due.delete();
      pq_idx.delete();
      acc = '0;
      prod_valid = 1'b0;
      nz_ready = 1'b0;
      rp_data = '0;
      prev_nzv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      prod_valid = 1'b0;
      pval = '0;
      injected = 1'b0;
      if (pq_due.size() > 0 && pq_due[0] == cyc) begin
        prod_valid = 1'b1;
        pval = val_mem[pq_idx[0]];
        void'(pq_due.pop_front());
        void'(pq_idx.pop_front());
      end
      if (inj_emit && row_valid && !prod_valid) begin
        prod_valid = 1'b1;
        injected = 1'b1;
        pval = 32'h0000_0BAD;
        inj_seen++;
      end
      rp_data = rd_next;
      case (rdy_mode)
        0:       nz_ready = 1'b1;
        1:       begin nz_ready = tog; tog = !tog; end
        default: nz_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (injected && acc_en) inj_accen++;
      if (row_valid) begin
        rv_idx.push_back(int'(row_idx));
        rv_sum.push_back(acc);
      end
      if (acc_clear && acc_en) viol_cnt++;
      if (prev_nzv && !prev_hs && !nz_valid) viol_cnt++;
      prev_nzv = nz_valid;
      prev_hs = nz_valid && nz_ready;
      if (acc_clear) acc = '0;
      else if (acc_en) acc = acc + pval;
      if (rp_rd) begin
        rd_next = rp_mem[rp_addr[5:0]];
        rprd_cnt++;
        if (first_addr < 0) first_addr = int'(rp_addr);
      end else begin
        rd_next = 16'($urandom);
      end
      if (nz_valid && nz_ready) begin
        iss_q.push_back(int'(nz_idx));
        pq_due.push_back(cyc + dly);
        pq_idx.push_back(int'(nz_idx));
      end
      if (done) done_cnt++;
      if (busy && nz_valid && !nz_ready) stall_cnt++;
      else if (busy && !nz_valid && !row_valid && !acc_clear && !done && !rp_rd) stall_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    iss_q.delete();
    rv_idx.delete();
    rv_sum.delete();
    done_cnt = 0; rprd_cnt = 0; stall_cnt = 0; viol_cnt = 0;
    first_addr = -1; inj_seen = 0; inj_accen = 0;
  endtask

  task automatic run_pass(input string tag, input int nr, input int mode, input int d,
                          input bit busy_start, input bit exp_err);
    int          exp_iss[$];
    logic [31:0] exp_sum[$];
    logic [31:0] s;
    int          k, bad, n;
    for (int r = 0; r < nr; r++) begin
      s = '0;
      for (int j = int'(rp_mem[r]); j < int'(rp_mem[r+1]); j++) begin
        exp_iss.push_back(j);
        s = s + val_mem[j];
      end
      exp_sum.push_back(s);
    end
    clear_logs();
    rdy_mode = mode; dly = d; tog = 1'b1;
    @(negedge clk);
    start = 1'b1; num_rows = 16'(nr);
    @(negedge clk);
    start = 1'b0; num_rows = 16'($urandom);
    k = 0;
    while (done_cnt == 0 && k < 4000) begin
      @(negedge clk);
      k++;
      if (busy_start && k == 4) begin start = 1'b1; num_rows = 16'(nr + 3); end
      else start = 1'b0;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (4) @(negedge clk);
    chk({tag, " issue_count"}, 64'(iss_q.size()), 64'(exp_iss.size()));
    n = (iss_q.size() < exp_iss.size()) ? iss_q.size() : exp_iss.size();
    bad = 0;
    for (int i = 0; i < n; i++) if (iss_q[i] != exp_iss[i]) bad++;
    chk({tag, " issue_order_errors"}, 64'(bad), 64'd0);
    chk({tag, " row_count"}, 64'(rv_idx.size()), 64'(nr));
    n = (rv_idx.size() < nr) ? rv_idx.size() : nr;
    bad = 0;
    for (int i = 0; i < n; i++) if (rv_idx[i] != i || rv_sum[i] !== exp_sum[i]) bad++;
    chk({tag, " row_sum_errors"}, 64'(bad), 64'd0);
    chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, " err"}, 64'(err), 64'(exp_err));
    chk({tag, " protocol_violations"}, 64'(viol_cnt), 64'd0);
    chk({tag, " rp_reads"}, 64'(rprd_cnt), 64'(nr + 1));
    chk({tag, " first_rp_addr"}, 64'(first_addr), 64'd0);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
`ifdef SMVM_SEQ_PERF_EN
    chk({tag, " perf_stall"}, 64'(perf_stall), 64'(stall_cnt));
`else
    chk({tag, " perf_stall"}, 64'(perf_stall), 64'd0);
`endif
  endtask

  task automatic load_rp(input int a0, input int a1, input int a2, input int a3);
    rp_mem[0] = 16'(a0); rp_mem[1] = 16'(a1); rp_mem[2] = 16'(a2); rp_mem[3] = 16'(a3);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nr;
    for (int i = 0; i < 64; i++) rp_mem[i] = '0;
    for (int i = 0; i < 1024; i++) val_mem[i] = $urandom;
    clear_logs();

    // Reset state
    #2 rst_l = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset outputs", {rp_rd, rp_addr, nz_valid, nz_idx, acc_en, acc_clear, row_valid,
                          row_idx, busy, done, err}, '0);
    chk("reset perf_stall", 64'(perf_stall), 64'd0);
    @(negedge clk); #2 rst_l = 1'b1;
    repeat (2) @(negedge clk);

    // Directed matrix, always ready, then toggling ready
    load_rp(0, 3, 3, 5);
    run_pass("basic", 3, 0, 2, 1'b0, 1'b0);
    run_pass("toggle", 3, 1, 2, 1'b0, 1'b0);

    // Zero-row pass
    clear_logs();
    @(negedge clk);
    start = 1'b1; num_rows = '0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 20) begin @(negedge clk); k++; end
    chk("zero_rows done_latency_ok", 64'(k <= 2), 64'd1);
    repeat (3) @(negedge clk);
    chk("zero_rows done_count", 64'(done_cnt), 64'd1);
    chk("zero_rows activity", 64'(rprd_cnt + iss_q.size() + rv_idx.size()), 64'd0);

    // Randomized matrices
    for (int p = 0; p < 7; p++) begin
      nr = $urandom_range(1, 8);
      rp_mem[0] = 16'($urandom_range(0, 5));
      for (int r = 0; r < nr; r++) rp_mem[r+1] = rp_mem[r] + 16'($urandom_range(0, 4));
      run_pass($sformatf("rand%0d", p), nr, p % 3, $urandom_range(1, 4), (p == 6), 1'b0);
    end

    // Start pulsed while busy on the directed matrix
    load_rp(0, 3, 3, 5);
    run_pass("busy_start", 3, 2, 3, 1'b1, 1'b0);

    // Stray product during EMIT
    inj_emit = 1'b1;
    run_pass("emit_prod", 3, 0, 2, 1'b0, 1'b1);
    inj_emit = 1'b0;
    chk("emit_prod injected", 64'(inj_seen != 0), 64'd1);
    chk("emit_prod acc_en_low", 64'(inj_accen), 64'd0);
    repeat (5) @(negedge clk);
    chk("emit_prod err_sticky", 64'(err), 64'd1);

    // Reset while issuing row 1
    load_rp(0, 2, 5, 6);
    clear_logs();
    rdy_mode = 0; dly = 2;
    @(negedge clk);
    start = 1'b1; num_rows = 16'd3;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(row_idx == 16'd1 && nz_valid) && k < 200) begin @(negedge clk); k++; end
    chk("midreset reached_row1_issue", 64'(k < 200), 64'd1);
    #2 rst_l = 1'b0;
    #1;
    chk("midreset outputs", {rp_rd, rp_addr, nz_valid, nz_idx, acc_en, acc_clear, row_valid,
                             row_idx, busy, done, err}, '0);
    chk("midreset perf_stall", 64'(perf_stall), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_l = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset no_done", 64'(done_cnt), 64'd0);
    run_pass("after_reset", 3, 1, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
